wb_crypto_bridge: RTL and testbench
===================================

# wb_crypto_bridge

Wishbone classic slave bridge from the Caravel management bus to NUM_CORES register-mapped crypto cores (blake2s, aes and successors), all sharing the cs/we/address/write_data/read_data port style. Replaces the flat, unacknowledged wiring of a single core with a registered request path:

- address decode to one of several cores;
- a one-cycle `wbs_ack_o` handshake;
- a configurable core read latency;
- read-modify-write for byte-lane writes.

It sits between the user-project Wishbone port and the crypto core instances.

## Interface
- NUM_CORES, 2: number of attached cores (1..8).
- ADDR_W, 8: core register address width.
- ADDR_LSB, 2: lowest `wbs_adr_i` bit of the core address. The core index field starts at ADDR_LSB+ADDR_W and is 3 bits wide.
- READ_LAT, 1: cycles from core cs to valid core read data (1..4).
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge; one-cycle pulse.
- wbs_dat_o  out  32  read data; valid only while `wbs_ack_o` is high, 0 otherwise.
- wbs_err_o  out  1  error pulse (see Configuration).
- core_cs_o  out  NUM_CORES  one-hot core select; one-cycle pulse.
- core_we_o  out  1  core write enable.
- core_addr_o  out  ADDR_W  core register address.
- core_wdata_o  out  32  core write data.
- core_rdata_i  in  32*NUM_CORES  concatenated core read data; core k occupies bits [32k+31:32k].

## Operation
FSM states: IDLE, RD, RWAIT, WR, ACK.

- **IDLE**
  - A request is `wbs_cyc_i & wbs_stb_i`.
  - On a request, latch address, data, we, sel and core index.
  - Unmapped index (≥ NUM_CORES) → ACK with response data 0.
  - Write with sel=4'hF → WR.
  - Write with sel=4'h0 → ACK; no core access.
  - Read, or any other partial write → RD.
- **RD**
  - Assert `core_cs_o[idx]` with `core_we_o`=0 for exactly one cycle.
  - Load the wait counter with READ_LAT-1, then → RWAIT.
- **RWAIT**
  - Decrement the counter.
  - At 0, capture `core_rdata_i[idx]`.
  - Read → ACK.
  - Partial write → merge (byte lane i takes `wbs_dat_i` if sel[i], else the captured data) → WR.
- **WR**
  - Assert `core_cs_o[idx]` with `core_we_o`=1 and `core_wdata_o` = full or merged word for one cycle → ACK.
- **ACK**
  - Pulse `wbs_ack_o`; `wbs_dat_o` = captured data for reads, 0 for writes → IDLE.
  - A request still present in the following IDLE cycle is treated as a new transfer. A master holding stb after ack therefore gets a second transfer; masters must drop stb after ack.
- **Abort:** `wbs_cyc_i` low in RD, RWAIT or WR (sampled before the state's action) → IDLE, with no core access issued in that state and no ack.
- **Reset:**
  - Reset value of every output is 0 and the state is IDLE.
  - Reset mid-transfer drops the transfer silently; `core_cs_o` is 0 from the cycle after reset is sampled.
- `core_addr_o`, `core_we_o` and `core_wdata_o` hold their latched values between transfers. They are meaningful only while `core_cs_o` ≠ 0.

## Timing
Request sampled at edge T:

- Full write: WR at T+1, ack at T+2.
- Read: RD at T+1, data captured at end of cycle T+1+READ_LAT, ack at T+2+READ_LAT. With READ_LAT=1, ack is at T+3.
- Partial write: WR at T+2+READ_LAT, ack at T+3+READ_LAT.
- Unmapped access or sel=0 write: ack at T+1.
- At most one outstanding transfer; no pipelining.

## Configuration
Macro WB_CRYPTO_BRIDGE_ERR_EN:

- **Defined:** an unmapped core index pulses `wbs_err_o` instead of `wbs_ack_o`, at the same cycle (T+1). `wbs_dat_o` stays 0.
- **Undefined:** `wbs_err_o` is tied 0; unmapped accesses ack with data 0 and writes are discarded.

## Structure
- **Package `wb_crypto_bridge_pkg`:**
  - state enum (IDLE, RD, RWAIT, WR, ACK);
  - core-index field width (3);
  - READ_LAT counter width (2);
  - parameter-check constants (NUM_CORES ≤ 8, 1 ≤ READ_LAT ≤ 4).
- **Sub-module `wb_byte_merge`:** combinational; 32-bit old word, 32-bit new word, 4-bit sel → merged word. Shared with future bridges.

## Test plan
- Full write 0xA5A5_5A5A to core 1, address 0x10, READ_LAT=1 → `core_cs_o`=2'b10, `core_we_o`=1, `core_addr_o`=0x10 at T+1; ack at T+2.
- Read core 0, address 0x08, core returns 0x1234_5678 one cycle after cs → ack at T+3 with `wbs_dat_o`=0x1234_5678; `wbs_dat_o`=0 on the cycle after ack.
- Partial write sel=4'b0010, data 0x0000_AB00, core word 0x1122_3344 → read cs, then write cs with 0x1122_AB44; ack at T+4.
- READ_LAT=3 read → ack at T+5; data sampled at T+4, not at T+3.
- Core index 5 with NUM_CORES=2:
  - macro defined: `wbs_err_o` pulse at T+1, no ack, `core_cs_o` stays 0;
  - macro undefined: ack at T+1 with data 0.
- Drop `wbs_cyc_i` during RWAIT of a partial write → no WR cs, no ack, FSM in IDLE. Assert `wb_rst_i` mid-read → all outputs 0 and the next transfer completes normally.

Source files
------------

// File: rtl/wb_crypto_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-crypto-core bridge.
package wb_crypto_bridge_pkg;

    localparam int unsigned CoreIdxW   = 3;
    localparam int unsigned LatCntW    = 2;
    localparam int unsigned MinCores   = 1;
    localparam int unsigned MaxCores   = 8;
    localparam int unsigned MinReadLat = 1;
    localparam int unsigned MaxReadLat = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRwait,
        StWr,
        StAck
    } state_e;

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge: each lane takes the new word where its select bit is set,
// otherwise keeps the old word.
module wb_byte_merge (
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_word,
    input  logic [3:0]  i_sel,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (i_sel[i]) begin
                o_merged[8*i +: 8] = i_new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_crypto_bridge.sv
// Wishbone classic slave bridge to NUM_CORES register-mapped crypto cores.
// Define WB_CRYPTO_BRIDGE_ERR_EN to answer unmapped core indices with wbs_err_o.
module wb_crypto_bridge
    import wb_crypto_bridge_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ADDR_LSB  = 2,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    wbs_err_o,
    output logic [NUM_CORES-1:0]    core_cs_o,
    output logic                    core_we_o,
    output logic [ADDR_W-1:0]       core_addr_o,
    output logic [31:0]             core_wdata_o,
    input  logic [32*NUM_CORES-1:0] core_rdata_i
);

    localparam int unsigned IdxLsb = ADDR_LSB + ADDR_W;

    if (NUM_CORES < MinCores || NUM_CORES > MaxCores) begin : g_bad_num_cores
        $error("wb_crypto_bridge: NUM_CORES out of range");
    end
    if (READ_LAT < MinReadLat || READ_LAT > MaxReadLat) begin : g_bad_read_lat
        $error("wb_crypto_bridge: READ_LAT out of range");
    end
    if (IdxLsb + CoreIdxW > 32) begin : g_bad_addr_map
        $error("wb_crypto_bridge: core index field exceeds wbs_adr_i");
    end

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_we;
    logic                   r_core_we;
    logic [3:0]             r_sel;
    logic [CoreIdxW-1:0]    r_idx;
    logic [LatCntW-1:0]     r_cnt;

    logic                   w_req;
    logic [CoreIdxW-1:0]    w_req_idx;
    logic [ADDR_W-1:0]      w_req_addr;
    logic                   w_req_mapped;
    logic                   w_full_wr;
    logic                   w_null_wr;
    logic [31:0]            w_core_rdata;
    logic [31:0]            w_merged;
    logic [NUM_CORES-1:0]   w_cs_hot;
    logic                   w_unused_adr;

    assign w_req        = wbs_cyc_i & wbs_stb_i;
    assign w_req_idx    = wbs_adr_i[IdxLsb +: CoreIdxW];
    assign w_req_addr   = wbs_adr_i[ADDR_LSB +: ADDR_W];
    assign w_req_mapped = (32'(w_req_idx) < NUM_CORES);
    assign w_full_wr    = wbs_we_i & (wbs_sel_i == 4'hF);
    assign w_null_wr    = wbs_we_i & (wbs_sel_i == 4'h0);
    assign w_unused_adr = ^wbs_adr_i;

    always_comb begin
        w_core_rdata = '0;
        w_cs_hot     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (r_idx == CoreIdxW'(k)) begin
                w_core_rdata = core_rdata_i[32*k +: 32];
                w_cs_hot[k]  = 1'b1;
            end
        end
    end

    wb_byte_merge u_merge (
        .i_old_word (w_core_rdata),
        .i_new_word (r_wdata),
        .i_sel      (r_sel),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (!w_req_mapped || w_null_wr) begin
                        w_state_next = StAck;
                    end else if (w_full_wr) begin
                        w_state_next = StWr;
                    end else begin
                        w_state_next = StRd;
                    end
                end
            end
            StRd:    w_state_next = wbs_cyc_i ? StRwait : StIdle;
            StRwait: begin
                if (!wbs_cyc_i) begin
                    w_state_next = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_next = r_we ? StWr : StAck;
                end
            end
            StWr:    w_state_next = wbs_cyc_i ? StAck : StIdle;
            StAck:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

`ifdef WB_CRYPTO_BRIDGE_ERR_EN
    logic r_unmapped;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_unmapped <= 1'b0;
        end else if (r_state == StIdle && w_req) begin
            r_unmapped <= ~w_req_mapped;
        end
    end

    assign wbs_ack_o = (r_state == StAck) & ~r_unmapped;
    assign wbs_err_o = (r_state == StAck) &  r_unmapped;
`else
    assign wbs_ack_o = (r_state == StAck);
    assign wbs_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_core_we <= 1'b0;
            r_sel     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_addr    <= w_req_addr;
                        r_wdata   <= wbs_dat_i;
                        r_we      <= wbs_we_i;
                        r_core_we <= w_full_wr;
                        r_sel     <= wbs_sel_i;
                        r_idx     <= w_req_idx;
                        // Unmapped and sel=0 transfers answer with this zero.
                        r_rdata   <= '0;
                    end
                end
                StRd: begin
                    if (wbs_cyc_i) begin
                        r_cnt <= LatCntW'(READ_LAT - 1);
                    end
                end
                StRwait: begin
                    if (wbs_cyc_i) begin
                        if (r_cnt == '0) begin
                            r_rdata   <= w_core_rdata;
                            r_core_we <= r_we;
                            if (r_we) begin
                                r_wdata <= w_merged;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by cyc so an abort in RD/WR suppresses the access in the same cycle.
    assign core_cs_o    = (((r_state == StRd) || (r_state == StWr)) && wbs_cyc_i) ?
                          w_cs_hot : '0;
    assign core_we_o    = r_core_we;
    assign core_addr_o  = r_addr;
    assign core_wdata_o = r_wdata;
    assign wbs_dat_o    = (wbs_ack_o && !r_we) ? r_rdata : '0;

endmodule

// File: tb/tb_wb_crypto_bridge.sv
// Scoreboard bench: two bridges (READ_LAT 1 and 3) with behavioural core models.
module tb_wb_crypto_bridge;

`ifdef WB_CRYPTO_BRIDGE_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        int          core;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } cwr_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic        cyc_s [2];
    logic        stb_s [2];
    logic        we_s  [2];
    logic [3:0]  sel_s [2];
    logic [31:0] adr_s [2];
    logic [31:0] dat_s [2];

    logic        ack    [2];
    logic        err    [2];
    logic [31:0] dat_o  [2];
    logic [1:0]  cs     [2];
    logic        cwe    [2];
    logic [7:0]  caddr  [2];
    logic [31:0] cwdata [2];

    resp_t exp_resp [2][$];
    cwr_t  exp_wr   [2][$];
    int    ack_seen [2];
    int    wr_seen  [2];
    int    rd_seen  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_bench
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [31:0] mem  [2][256];
        logic [31:0] pipe [2][4];
        logic [63:0] core_rdata;

        wb_crypto_bridge #(
            .NUM_CORES (2),
            .ADDR_W    (8),
            .ADDR_LSB  (2),
            .READ_LAT  (Lat)
        ) u_dut (
            .wb_clk_i     (clk),
            .wb_rst_i     (rst),
            .wbs_stb_i    (stb_s[g]),
            .wbs_cyc_i    (cyc_s[g]),
            .wbs_we_i     (we_s[g]),
            .wbs_sel_i    (sel_s[g]),
            .wbs_adr_i    (adr_s[g]),
            .wbs_dat_i    (dat_s[g]),
            .wbs_ack_o    (ack[g]),
            .wbs_dat_o    (dat_o[g]),
            .wbs_err_o    (err[g]),
            .core_cs_o    (cs[g]),
            .core_we_o    (cwe[g]),
            .core_addr_o  (caddr[g]),
            .core_wdata_o (cwdata[g]),
            .core_rdata_i (core_rdata)
        );

        // Core read data appears Lat cycles after cs; filler elsewhere exposes early capture.
        always @(posedge clk) begin
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    for (int a = 0; a < 256; a++) mem[k][a] <= 32'h0;
                    for (int j = 0; j < 4; j++) pipe[k][j] <= 32'h0;
                end else begin
                    pipe[k][0] <= (cs[g][k] && !cwe[g]) ? mem[k][caddr[g]] : 32'hDEAD_BEEF;
                    for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
                    if (cs[g][k] && cwe[g]) mem[k][caddr[g]] <= cwdata[g];
                end
            end
            if (rst) begin
                mem[0][8'h08] <= 32'h1234_5678;
                mem[0][8'h30] <= 32'h5566_7788;
                mem[1][8'h20] <= 32'h1122_3344;
            end
        end

        assign core_rdata = {pipe[1][Lat-1], pipe[0][Lat-1]};

        initial begin
            resp_t e;
            bit    prev;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (ack[g] || err[g]) begin
                    ack_seen[g]++;
                    if (exp_resp[g].size() == 0) begin
                        n_chk++;
                        $display("FAIL resp%0d_unexpected: ack=%0b err=%0b dat=%h cycle=%0d",
                                 g, ack[g], err[g], dat_o[g], cycle);
                    end else begin
                        e = exp_resp[g].pop_front();
                        chk($sformatf("resp%0d_err", g), {63'd0, err[g]}, {63'd0, e.err});
                        chk($sformatf("resp%0d_data", g), {32'd0, dat_o[g]}, {32'd0, e.data});
                        chk($sformatf("resp%0d_cycle", g), 64'(cycle), 64'(e.cyc));
                    end
                end else if (prev) begin
                    chk($sformatf("resp%0d_dat_after_ack", g), {32'd0, dat_o[g]}, 64'd0);
                end
                prev = ack[g] || err[g];
            end
        end

        initial begin
            cwr_t e;
            forever begin
                @(negedge clk);
                if (cs[g][0] && cs[g][1]) begin
                    n_chk++;
                    $display("FAIL cs%0d_onehot: got %b", g, cs[g]);
                end
                for (int k = 0; k < 2; k++) begin
                    if (cs[g][k] && !cwe[g]) rd_seen[g]++;
                    if (cs[g][k] && cwe[g]) begin
                        wr_seen[g]++;
                        if (exp_wr[g].size() == 0) begin
                            n_chk++;
                            $display("FAIL wr%0d_unexpected: core=%0d addr=%h data=%h cycle=%0d",
                                     g, k, caddr[g], cwdata[g], cycle);
                        end else begin
                            e = exp_wr[g].pop_front();
                            chk($sformatf("wr%0d_core", g), 64'(k), 64'(e.core));
                            chk($sformatf("wr%0d_addr", g), {56'd0, caddr[g]}, {56'd0, e.addr});
                            chk($sformatf("wr%0d_data", g), {32'd0, cwdata[g]}, {32'd0, e.data});
                            chk($sformatf("wr%0d_cycle", g), 64'(cycle), 64'(e.cyc));
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int g, input bit we, input logic [3:0] sel, input int idx,
                         input logic [7:0] a, input logic [31:0] d);
        cyc_s[g] = 1'b1;
        stb_s[g] = 1'b1;
        we_s[g]  = we;
        sel_s[g] = sel;
        adr_s[g] = 32'((idx << 10) | (int'(a) << 2));
        dat_s[g] = d;
    endtask

    task automatic release_bus(input int g);
        cyc_s[g] = 1'b0;
        stb_s[g] = 1'b0;
    endtask

    // lat/wr_lat are cycles from the sampling edge T to ack / write cs, as in the timing table.
    task automatic xfer(input int g, input bit we, input logic [3:0] sel, input int idx,
                        input logic [7:0] a, input logic [31:0] d, input int lat,
                        input bit exp_err, input logic [31:0] exp_d,
                        input bit has_wr, input int wr_lat, input logic [31:0] wr_d);
        int  t;
        bit  done;
        repeat (2) @(negedge clk);
        drive(g, we, sel, idx, a, d);
        t = cycle + 1;
        exp_resp[g].push_back('{err: exp_err, data: exp_d, cyc: t + lat - 1});
        if (has_wr) exp_wr[g].push_back('{core: idx, addr: a, data: wr_d, cyc: t + wr_lat - 1});
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
            done = ack[g] || err[g];
        end
        if (!done) begin
            n_chk++;
            $display("FAIL xfer%0d_timeout: no ack/err within 30 cycles, adr=%h", g, adr_s[g]);
        end
        release_bus(g);
    endtask

    task automatic abort_pw(input int g, input int idx, input logic [7:0] a,
                            input logic [3:0] sel, input logic [31:0] d);
        int ack0;
        int wr0;
        repeat (2) @(negedge clk);
        drive(g, 1'b1, sel, idx, a, d);
        ack0 = ack_seen[g];
        wr0  = wr_seen[g];
        // Land inside RWAIT before dropping cyc.
        repeat ((g == 0) ? 2 : 3) @(posedge clk);
        #1;
        release_bus(g);
        repeat (8) @(posedge clk);
        chk($sformatf("abort%0d_no_ack", g), 64'(ack_seen[g]), 64'(ack0));
        chk($sformatf("abort%0d_no_wr", g), 64'(wr_seen[g]), 64'(wr0));
    endtask

    task automatic chk_outputs_zero(input string name, input int g);
        chk({name, "_ctl"}, {52'd0, ack[g], err[g], cs[g], cwe[g], caddr[g]}, 64'd0);
        chk({name, "_dat"}, {32'd0, dat_o[g]}, 64'd0);
        chk({name, "_wdata"}, {32'd0, cwdata[g]}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            release_bus(g);
            we_s[g]  = 1'b0;
            sel_s[g] = 4'h0;
            adr_s[g] = 32'h0;
            dat_s[g] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset0", 0);
        chk_outputs_zero("reset1", 1);
        rst = 1'b0;

        // READ_LAT = 1 bridge
        xfer(0, 1, 4'hF, 1, 8'h10, 32'hA5A5_5A5A, 2, 0, 32'h0, 1, 1, 32'hA5A5_5A5A);
        xfer(0, 0, 4'hF, 1, 8'h10, 32'h0, 3, 0, 32'hA5A5_5A5A, 0, 0, 32'h0);
        xfer(0, 0, 4'hF, 0, 8'h08, 32'h0, 3, 0, 32'h1234_5678, 0, 0, 32'h0);
        xfer(0, 1, 4'b0010, 1, 8'h20, 32'h0000_AB00, 4, 0, 32'h0, 1, 3, 32'h1122_AB44);
        xfer(0, 0, 4'hF, 1, 8'h20, 32'h0, 3, 0, 32'h1122_AB44, 0, 0, 32'h0);
        xfer(0, 1, 4'b1001, 0, 8'h30, 32'hAABB_CCDD, 4, 0, 32'h0, 1, 3, 32'hAA66_77DD);
        xfer(0, 0, 4'hF, 0, 8'h30, 32'h0, 3, 0, 32'hAA66_77DD, 0, 0, 32'h0);
        xfer(0, 1, 4'h0, 0, 8'h08, 32'hFFFF_FFFF, 1, 0, 32'h0, 0, 0, 32'h0);
        xfer(0, 0, 4'hF, 0, 8'h08, 32'h0, 3, 0, 32'h1234_5678, 0, 0, 32'h0);

        rd0 = rd_seen[0];
        xfer(0, 0, 4'hF, 5, 8'h10, 32'h0, 1, ErrEn, 32'h0, 0, 0, 32'h0);
        xfer(0, 1, 4'hF, 5, 8'h10, 32'hCAFE_F00D, 1, ErrEn, 32'h0, 0, 0, 32'h0);
        chk("unmapped_no_core_read", 64'(rd_seen[0]), 64'(rd0));
        xfer(0, 0, 4'hF, 1, 8'h10, 32'h0, 3, 0, 32'hA5A5_5A5A, 0, 0, 32'h0);

        abort_pw(0, 1, 8'h10, 4'b0010, 32'h0000_7700);
        xfer(0, 0, 4'hF, 1, 8'h10, 32'h0, 3, 0, 32'hA5A5_5A5A, 0, 0, 32'h0);

        // READ_LAT = 3 bridge
        xfer(1, 0, 4'hF, 0, 8'h08, 32'h0, 5, 0, 32'h1234_5678, 0, 0, 32'h0);
        xfer(1, 1, 4'b0100, 1, 8'h20, 32'h00EE_0000, 6, 0, 32'h0, 1, 5, 32'h11EE_3344);
        xfer(1, 0, 4'hF, 1, 8'h20, 32'h0, 5, 0, 32'h11EE_3344, 0, 0, 32'h0);
        abort_pw(1, 1, 8'h20, 4'b0001, 32'h0000_0099);
        xfer(1, 0, 4'hF, 1, 8'h20, 32'h0, 5, 0, 32'h11EE_3344, 0, 0, 32'h0);

        // Reset in the middle of a read on the READ_LAT = 1 bridge
        repeat (2) @(negedge clk);
        drive(0, 1'b0, 4'hF, 0, 8'h08, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_read_cs", {62'd0, cs[0]}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("rst_mid_read", 0);
        @(negedge clk);
        rst = 1'b0;
        release_bus(0);
        xfer(0, 0, 4'hF, 0, 8'h08, 32'h0, 3, 0, 32'h1234_5678, 0, 0, 32'h0);

        repeat (5) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("resp%0d_queue_drained", g), 64'(exp_resp[g].size()), 64'd0);
            chk($sformatf("wr%0d_queue_drained", g), 64'(exp_wr[g].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
